bram_chan_fifo_array: RTL and testbench

//  Array of NUM_CH independent single-clock BRAM FIFOs with wide-write / narrow-read width conversion.

---
 rtl/bram_chan_fifo_array_if.sv | 32 +++
 rtl/bram_chan_fifo_array.sv | 164 ++++++++++++++++
 tb/tb_bram_chan_fifo_array.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_chan_fifo_array_if.sv
// Bundle of per-channel write/read handshake signals for bram_chan_fifo_array.
// master: producer/consumer side (drives wr_en, wr_data, rd_ready, err_clr)
// slave : FIFO array side (drives wr_full, rd_valid, rd_data, level, err)
// Channel c occupies index [c] of every packed per-channel vector.
interface bram_chan_fifo_array_if #(
    parameter int NUM_CH = 16,
    parameter int WR_W   = 128,
    parameter int RD_W   = 8,
    parameter int DEPTH  = 512
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_CH-1:0]           wr_en;
    logic [NUM_CH-1:0][WR_W-1:0] wr_data;
    logic [NUM_CH-1:0]           wr_full;
    logic [NUM_CH-1:0]           rd_ready;
    logic [NUM_CH-1:0]           rd_valid;
    logic [NUM_CH-1:0][RD_W-1:0] rd_data;
    logic [NUM_CH-1:0][AW:0]     level;
    logic [NUM_CH-1:0]           err;
    logic                        err_clr;

    modport master (
        output wr_en, wr_data, rd_ready, err_clr,
        input  wr_full, rd_valid, rd_data, level, err
    );

    modport slave (
        input  wr_en, wr_data, rd_ready, err_clr,
        output wr_full, rd_valid, rd_data, level, err
    );
endinterface

// File: rtl/bram_chan_fifo_array.sv
// bram_chan_fifo_array: NUM_CH independent BRAM FIFOs, WR_W-bit line in,
// RD_W-bit beats out (LSB beat first), valid/ready on the read side.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset (stored data discarded, RAM untouched)
//   bus  - bram_chan_fifo_array_if.slave: wr_en/wr_data/wr_full,
//          rd_ready/rd_valid/rd_data, level (0..DEPTH), err/err_clr
// Optional: define BRAM_CHAN_FIFO_ERR_EN to build the sticky overflow flags;
// otherwise err is tied low and err_clr is ignored.

// One channel: RAM, pointers, occupancy and a 2-entry line buffer.
module bram_chan_fifo_lane #(
    parameter int WR_W  = 128,
    parameter int RD_W  = 8,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [WR_W-1:0] wr_data,
    output logic            wr_full,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [RD_W-1:0] rd_data,
    output logic [AW:0]     level
);
    localparam int RATIO = WR_W / RD_W;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RM1   = RATIO - 1;
    localparam logic [CW-1:0] LAST     = RM1[CW-1:0];
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [AW-1:0] ONE_A    = 1;

    logic [WR_W-1:0] mem [DEPTH];
    logic [WR_W-1:0] ram_q, ram_q2, nxt_d, cur_sh;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     lvl, pend, lvl_nx, pend_nx;
    logic [1:0]      vld_pipe;     // fetch in flight: [0] RAM read, [1] output reg
    logic            cur_v, nxt_v, full_q;
    logic [CW-1:0]   beat;
    logic            wr_acc, pop, last_pop, fetch, land;
    logic [2:0]      busy;

    always_comb begin
        wr_acc   = wr_en && !full_q;
        pop      = cur_v && rd_ready;
        last_pop = pop && (beat == LAST);
        // Buffer slots already claimed, counting lines still in the read pipe.
        busy     = 3'(cur_v) + 3'(nxt_v) + 3'(vld_pipe[0]) + 3'(vld_pipe[1]);
        fetch    = (pend != '0) && (busy < 3'd2);
        land     = vld_pipe[1];
        // A line keeps its RAM slot until its last beat leaves.
        lvl_nx   = lvl + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, last_pop};
        pend_nx  = pend + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, fetch};
    end

    // RAM and its registered read path carry no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
        if (fetch)  ram_q <= mem[rd_ptr];
        ram_q2 <= ram_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lvl      <= '0;
            pend     <= '0;
            full_q   <= 1'b0;
            vld_pipe <= '0;
            cur_v    <= 1'b0;
            nxt_v    <= 1'b0;
            beat     <= '0;
            cur_sh   <= '0;
            nxt_d    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE_A;
            if (fetch)  rd_ptr <= rd_ptr + ONE_A;
            lvl      <= lvl_nx;
            pend     <= pend_nx;
            full_q   <= (lvl_nx == FULL_LVL);
            vld_pipe <= {vld_pipe[0], fetch};

            if (last_pop) begin
                // Refill CUR on the same edge so beats stream without a bubble.
                beat <= '0;
                if (nxt_v) begin
                    cur_sh <= nxt_d;
                    nxt_v  <= land;
                    if (land) nxt_d <= ram_q2;
                end else if (land) begin
                    cur_sh <= ram_q2;
                end else begin
                    cur_v <= 1'b0;
                end
            end else begin
                if (pop) begin
                    cur_sh <= cur_sh >> RD_W;
                    beat   <= beat + CW'(1);
                end
                // busy guarantees a free slot whenever a line lands.
                if (land) begin
                    if (!cur_v) begin
                        cur_v  <= 1'b1;
                        cur_sh <= ram_q2;
                        beat   <= '0;
                    end else begin
                        nxt_v <= 1'b1;
                        nxt_d <= ram_q2;
                    end
                end
            end
        end
    end

    assign wr_full  = full_q;
    assign rd_valid = cur_v;
    assign rd_data  = cur_sh[RD_W-1:0];
    assign level    = lvl;
endmodule

module bram_chan_fifo_array #(
    parameter int NUM_CH = 16,
    parameter int WR_W   = 128,
    parameter int RD_W   = 8,
    parameter int DEPTH  = 512
) (
    input logic                    clk,
    input logic                    rst,
    bram_chan_fifo_array_if.slave  bus
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bram_chan_fifo_lane #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (bus.wr_en[c]),
            .wr_data  (bus.wr_data[c]),
            .wr_full  (bus.wr_full[c]),
            .rd_ready (bus.rd_ready[c]),
            .rd_valid (bus.rd_valid[c]),
            .rd_data  (bus.rd_data[c]),
            .level    (bus.level[c])
        );
    end

`ifdef BRAM_CHAN_FIFO_ERR_EN
    logic [NUM_CH-1:0] err_q;

    // A new overflow outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= (bus.wr_en & bus.wr_full) | (err_q & {NUM_CH{~bus.err_clr}});
    end

    assign bus.err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.err        = '0;
`endif
endmodule

// File: tb/tb_bram_chan_fifo_array.sv
// Randomised scoreboard bench for bram_chan_fifo_array. Writes push their
// expected beats into per-channel queues; a negedge monitor pops and compares
// every presented beat and tracks level/wr_full/err with a counting model.
module tb_bram_chan_fifo_array;
    localparam int NUM_CH = 16;
    localparam int WR_W   = 128;
    localparam int RD_W   = 8;
    localparam int DEPTH  = 512;
    localparam int RATIO  = WR_W / RD_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_chan_fifo_array_if #(.NUM_CH(NUM_CH), .WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) bus ();

    bram_chan_fifo_array #(.NUM_CH(NUM_CH), .WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [RD_W-1:0] exp_q [NUM_CH][$];
    int              exp_level [NUM_CH];
    bit              exp_err   [NUM_CH];
    int              beats     [NUM_CH];
    int              n_lines   [NUM_CH];
    bit              held_v    [NUM_CH];
    logic [RD_W-1:0] held_d    [NUM_CH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WR_W-1:0] rand_line();
        logic [WR_W-1:0] d;
        for (int w = 0; w < WR_W / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Issue a write for the coming edge; a line is accepted unless the channel is full.
    task automatic wr(input int c, input logic [WR_W-1:0] d);
        bus.wr_en[c]   = 1'b1;
        bus.wr_data[c] = d;
        if (exp_level[c] != DEPTH) begin
            for (int k = 0; k < RATIO; k++) exp_q[c].push_back(d[k*RD_W +: RD_W]);
            n_lines[c]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.wr_en   = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic wait_rv(input int c, input int bound, input string nm);
        int k = 0;
        while (!bus.rd_valid[c] && k < bound) begin
            step();
            k++;
        end
        chk(nm, bus.rd_valid[c], 1);
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NUM_CH; c++)
            if (exp_level[c] != 0 || exp_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: outputs are stable mid-cycle; inputs seen here apply at the next edge.
    always @(negedge clk) begin
        bit last, acc;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("level", bus.level[c], exp_level[c]);
            chk("wr_full", bus.wr_full[c], exp_level[c] == DEPTH);
            chk("err", bus.err[c], exp_err[c]);
            if (rst) begin
                exp_q[c].delete();
                exp_level[c] = 0;
                exp_err[c]   = 1'b0;
                beats[c]     = 0;
                held_v[c]    = 1'b0;
            end else begin
                if (held_v[c]) begin
                    chk("hold_valid", bus.rd_valid[c], 1);
                    chk("hold_data", bus.rd_data[c], held_d[c]);
                end
                last = 1'b0;
                if (bus.rd_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk("rd_valid_unexpected", bus.rd_valid[c], 0);
                    end else begin
                        chk("rd_data", bus.rd_data[c], exp_q[c][0]);
                        if (bus.rd_ready[c]) begin
                            void'(exp_q[c].pop_front());
                            beats[c]++;
                            if (beats[c] == RATIO) begin
                                beats[c] = 0;
                                last     = 1'b1;
                            end
                        end
                    end
                end
                acc = bus.wr_en[c] && (exp_level[c] != DEPTH);
`ifdef BRAM_CHAN_FIFO_ERR_EN
                if (bus.wr_en[c] && exp_level[c] == DEPTH) exp_err[c] = 1'b1;
                else if (bus.err_clr)                      exp_err[c] = 1'b0;
`endif
                exp_level[c] = exp_level[c] + int'(acc) - int'(last);
                held_v[c]    = bus.rd_valid[c] && !bus.rd_ready[c];
                held_d[c]    = bus.rd_data[c];
            end
        end
    end

    initial begin
        logic [WR_W-1:0] line0;
        int gaps, k;
        bit err_exp;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_level[c] = 0; exp_err[c] = 0; beats[c] = 0; n_lines[c] = 0; held_v[c] = 0;
            held_d[c] = '0;
        end
        rst         = 1'b1;
        bus.wr_en   = '0;
        bus.wr_data = '0;
        bus.rd_ready = '1;
        bus.err_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("reset_rd_data", bus.rd_data[c], 0);
            chk("reset_rd_valid", bus.rd_valid[c], 0);
        end

        // ch0: single line, 3-edge latency, beats 0x00..0x0F
        line0 = 128'h0F0E0D0C0B0A09080706050403020100;
        wr(0, line0);
        step();
        chk("lat_t", bus.rd_valid[0], 0);
        step();
        chk("lat_t1", bus.rd_valid[0], 0);
        step();
        chk("lat_t2", bus.rd_valid[0], 0);
        step();
        chk("lat_t3", bus.rd_valid[0], 1);
        chk("first_beat", bus.rd_data[0], 8'h00);
        repeat (20) step();

        // ch3: four lines back-to-back stream as 64 contiguous beats
        for (int i = 0; i < 4; i++) begin
            wr(3, rand_line());
            step();
        end
        wait_rv(3, 10, "ch3_start");
        gaps = 0;
        for (int i = 0; i < 64; i++) begin
            if (!bus.rd_valid[3]) gaps++;
            step();
        end
        chk("ch3_gaps", gaps, 0);
        chk("ch3_empty", bus.rd_valid[3], 0);

        // ch5: fill to DEPTH, overflow, err set/clear, full with same-cycle pop
        bus.rd_ready[5] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr(5, rand_line());
            step();
        end
        chk("ch5_level_full", bus.level[5], DEPTH);
        chk("ch5_wr_full", bus.wr_full[5], 1);
`ifdef BRAM_CHAN_FIFO_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        wr(5, rand_line());
        step();
        chk("ch5_drop_level", bus.level[5], DEPTH);
        chk("ch5_err_set", bus.err[5], err_exp);
        wr(5, rand_line());
        bus.err_clr = 1'b1;
        step();
        chk("ch5_err_set_wins", bus.err[5], err_exp);
        bus.err_clr = 1'b1;
        step();
        chk("ch5_err_clr", bus.err[5], 0);
        bus.rd_ready[5] = 1'b1;
        repeat (RATIO - 1) step();
        wr(5, rand_line());
        step();
        bus.rd_ready[5] = 1'b0;
        chk("ch5_pop_no_bypass", bus.level[5], DEPTH - 1);
        chk("ch5_full_drop", bus.wr_full[5], 0);
        bus.rd_ready[5] = 1'b1;

        // Random streaming; ch1 pushes 600 lines through so pointers wrap.
        k = 0;
        while (n_lines[1] < 600 && k < 40000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (c == 5 || c == 7) continue;
                bus.rd_ready[c] = ($urandom % 2) == 1;
                if (c == 1) begin
                    if (($urandom % 2) == 1) wr(1, rand_line());
                end else if (n_lines[c] < 60 && ($urandom % 8) == 0) begin
                    wr(c, rand_line());
                end
            end
            if (($urandom % 97) == 0) bus.err_clr = 1'b1;
            step();
            k++;
        end
        chk("stream_timeout", k < 40000, 1);
        bus.rd_ready = '1;
        k = 0;
        while (!all_empty() && k < 20000) begin
            step();
            k++;
        end
        chk("drain_timeout", k < 20000, 1);
        chk("ch1_level_zero", bus.level[1], 0);
        chk("ch1_idle", bus.rd_valid[1], 0);

        // ch7: reset in the middle of a line, then new data reads cleanly
        wr(7, rand_line());
        step();
        wr(7, rand_line());
        step();
        wait_rv(7, 10, "ch7_start");
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ch7_rst_valid", bus.rd_valid[7], 0);
        chk("ch7_rst_level", bus.level[7], 0);
        chk("ch7_rst_err", bus.err[7], 0);
        wr(7, rand_line());
        step();
        wait_rv(7, 10, "ch7_restart");
        k = 0;
        while (!all_empty() && k < 100) begin
            step();
            k++;
        end
        chk("ch7_drain_timeout", k < 100, 1);
        step();
        chk("final_idle", bus.rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
